// File: rtl/bf_pkg.sv
// bf_pkg: shared brainfuck core constants, opcodes and loop-controller state type
package bf_pkg;
  localparam int ADDR_W = 10;
  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_INC        = 8'h2B;
  localparam logic [7:0] OP_DEC        = 8'h2D;
  localparam logic [7:0] OP_RIGHT      = 8'h3E;
  localparam logic [7:0] OP_LEFT       = 8'h3C;
  localparam logic [7:0] OP_OUT        = 8'h2E;
  localparam logic [7:0] OP_IN         = 8'h2C;
  typedef enum logic [2:0] {RUN, SKIP, POP, WAIT, LOAD, ERR} loop_state_t;
endpackage

// File: rtl/loop_controller_if.sv
// loop_controller_if: fetch/decode, execute and loop-stack signals of the loop controller
interface loop_controller_if #(parameter int ADDR_W = bf_pkg::ADDR_W);
  logic              instr_valid;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              cell_zero;
  logic              skip;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_addr_out;
  logic [ADDR_W-1:0] stk_addr_in;
  logic              err;
  modport master (
    output instr_valid, instr, instr_pc, cell_zero, stk_addr_in,
    input  instr_ready, skip, pc_load, pc_target, stk_push, stk_pop, stk_addr_out, err
  );
  modport slave (
    input  instr_valid, instr, instr_pc, cell_zero, stk_addr_in,
    output instr_ready, skip, pc_load, pc_target, stk_push, stk_pop, stk_addr_out, err
  );
endinterface

// File: rtl/loop_controller.sv
// loop_controller: pushes/pops loop addresses, redirects fetch on ']' and skips zero-cell loops
module loop_controller
  import bf_pkg::*;
#(
  parameter int ADDR_W = bf_pkg::ADDR_W,
  parameter int DEPTH  = 32
) (
  input logic clk,
  input logic rst,
  loop_controller_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);
  loop_state_t state_q, state_d;
  logic [CW-1:0] depth_q, depth_d, nest_q, nest_d;
  logic push_q, push_d, pop_q, pop_d, load_q, load_d, skip_q, err_q;
  logic [ADDR_W-1:0] addr_q, addr_d, target_q, target_d;
  logic acc, is_open, is_close;
  assign bus.instr_ready  = (state_q == RUN) || (state_q == SKIP);
  assign bus.skip         = skip_q;
  assign bus.err          = err_q;
  assign bus.stk_push     = push_q;
  assign bus.stk_pop      = pop_q;
  assign bus.stk_addr_out = addr_q;
  assign bus.pc_load      = load_q;
  assign bus.pc_target    = target_q;
  assign acc      = bus.instr_valid & bus.instr_ready;
  assign is_open  = acc & (bus.instr == OP_LOOP_OPEN);
  assign is_close = acc & (bus.instr == OP_LOOP_CLOSE);
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    nest_d   = nest_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    load_d   = 1'b0;
    addr_d   = addr_q;
    target_d = target_q;
    case (state_q)
      RUN: begin
        if (is_open) begin
          if (bus.cell_zero) begin
            state_d = SKIP;
            nest_d  = CW'(1);
          end else if (depth_q == DMAX) begin
            state_d = ERR;
          end else begin
            push_d  = 1'b1;
            addr_d  = bus.instr_pc;
            depth_d = depth_q + CW'(1);
          end
        end else if (is_close) begin
          if (depth_q == '0) begin
            state_d = ERR;
          end else begin
            pop_d   = 1'b1;
            depth_d = depth_q - CW'(1);
            state_d = bus.cell_zero ? RUN : POP;
          end
        end
      end
      SKIP: begin
        if (is_open) begin
          state_d = (nest_q == DMAX) ? ERR : SKIP;
          nest_d  = (nest_q == DMAX) ? nest_q : nest_q + CW'(1);
        end else if (is_close) begin
          nest_d  = nest_q - CW'(1);
          state_d = (nest_q == CW'(1)) ? RUN : SKIP;
        end
      end
      POP: state_d = WAIT;
      WAIT: begin
        load_d   = 1'b1;
        target_d = bus.stk_addr_in;
        state_d  = LOAD;
      end
      LOAD: state_d = RUN;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      depth_q  <= '0;
      nest_q   <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      load_q   <= 1'b0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      nest_q   <= nest_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      load_q   <= load_d;
      skip_q   <= (state_d == SKIP);
      err_q    <= (state_d == ERR);
      addr_q   <= addr_d;
      target_q <= target_d;
    end
  end
endmodule

// File: tb/tb_loop_controller.sv
// tb_loop_controller: directed vector table plus hand sequences for the loop controller
module tb_loop_controller;
  import bf_pkg::*;
  typedef struct {
    logic       v;
    logic [7:0] op;
    logic [9:0] pc;
    logic       cz;
    logic [9:0] sin;
    logic       rdy;
    logic       push;
    logic       pop;
    logic [9:0] aout;
    logic       skp;
    logic       ld;
    logic [9:0] tgt;
    logic       er;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  vec_t vecs[18];
  loop_controller_if #(.ADDR_W(10)) bus ();
  loop_controller #(.ADDR_W(10), .DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic [7:0] op, logic [9:0] pc, logic cz, logic [9:0] sin,
                              logic rdy, logic push, logic pop, logic [9:0] aout, logic skp,
                              logic ld, logic [9:0] tgt, logic er);
    vec_t r;
    r.v = v; r.op = op; r.pc = pc; r.cz = cz; r.sin = sin; r.rdy = rdy; r.push = push;
    r.pop = pop; r.aout = aout; r.skp = skp; r.ld = ld; r.tgt = tgt; r.er = er;
    return r;
  endfunction
  function automatic logic [24:0] outs();
    return {bus.stk_push, bus.stk_pop, bus.stk_addr_out, bus.skip, bus.pc_load, bus.pc_target, bus.err};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] op, input logic [9:0] pc, input logic cz);
    bus.instr_valid = v;
    bus.instr = op;
    bus.instr_pc = pc;
    bus.cell_zero = cz;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(1'b0, 8'h00, 10'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    bus.stk_addr_in = '0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 10'h0, 1'b0);
    vecs[0]  = mk(1, OP_LOOP_OPEN,  10'h010, 0, 10'h000, 1, 1, 0, 10'h010, 0, 0, 10'h000, 0);
    vecs[1]  = mk(1, OP_INC,        10'h011, 0, 10'h000, 1, 0, 0, 10'h010, 0, 0, 10'h000, 0);
    vecs[2]  = mk(1, OP_LOOP_CLOSE, 10'h012, 1, 10'h000, 1, 0, 1, 10'h010, 0, 0, 10'h000, 0);
    vecs[3]  = mk(1, OP_LOOP_OPEN,  10'h020, 0, 10'h000, 1, 1, 0, 10'h020, 0, 0, 10'h000, 0);
    vecs[4]  = mk(1, OP_LOOP_CLOSE, 10'h025, 0, 10'h000, 1, 0, 1, 10'h020, 0, 0, 10'h000, 0);
    vecs[5]  = mk(1, OP_INC,        10'h026, 0, 10'h3FF, 0, 0, 0, 10'h020, 0, 0, 10'h000, 0);
    vecs[6]  = mk(1, OP_INC,        10'h026, 0, 10'h020, 0, 0, 0, 10'h020, 0, 1, 10'h020, 0);
    vecs[7]  = mk(1, OP_INC,        10'h026, 0, 10'h000, 0, 0, 0, 10'h020, 0, 0, 10'h020, 0);
    vecs[8]  = mk(1, OP_LOOP_OPEN,  10'h020, 0, 10'h000, 1, 1, 0, 10'h020, 0, 0, 10'h020, 0);
    vecs[9]  = mk(1, OP_LOOP_CLOSE, 10'h025, 1, 10'h000, 1, 0, 1, 10'h020, 0, 0, 10'h020, 0);
    vecs[10] = mk(1, OP_LOOP_OPEN,  10'h030, 1, 10'h000, 1, 0, 0, 10'h020, 1, 0, 10'h020, 0);
    vecs[11] = mk(1, OP_LOOP_OPEN,  10'h031, 0, 10'h000, 1, 0, 0, 10'h020, 1, 0, 10'h020, 0);
    vecs[12] = mk(1, OP_LOOP_CLOSE, 10'h032, 0, 10'h000, 1, 0, 0, 10'h020, 1, 0, 10'h020, 0);
    vecs[13] = mk(1, OP_LOOP_CLOSE, 10'h033, 0, 10'h000, 1, 0, 0, 10'h020, 0, 0, 10'h020, 0);
    vecs[14] = mk(1, OP_INC,        10'h034, 0, 10'h000, 1, 0, 0, 10'h020, 0, 0, 10'h020, 0);
    vecs[15] = mk(1, OP_LOOP_CLOSE, 10'h035, 1, 10'h000, 1, 0, 0, 10'h020, 0, 0, 10'h020, 1);
    vecs[16] = mk(1, OP_LOOP_OPEN,  10'h036, 0, 10'h000, 0, 0, 0, 10'h020, 0, 0, 10'h020, 1);
    vecs[17] = mk(0, OP_INC,        10'h037, 0, 10'h000, 0, 0, 0, 10'h020, 0, 0, 10'h020, 1);
    step();
    rst = 1'b0;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_ready", 32'(bus.instr_ready), 32'h1);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].pc, vecs[i].cz);
      bus.stk_addr_in = vecs[i].sin;
      chk($sformatf("vec%0d_ready", i), 32'(bus.instr_ready), 32'(vecs[i].rdy));
      step();
      chk($sformatf("vec%0d_outs", i), 32'(outs()),
          32'({vecs[i].push, vecs[i].pop, vecs[i].aout, vecs[i].skp, vecs[i].ld, vecs[i].tgt, vecs[i].er}));
    end
    do_reset();
    chk("err_cleared", 32'({bus.err, bus.instr_ready}), 32'b01);
    chk("err_reset_outs", 32'(outs()), 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, OP_LOOP_OPEN, 10'(10'h100 + i), 1'b0);
      step();
      chk($sformatf("nest%0d_push", i), 32'({bus.stk_push, bus.stk_addr_out, bus.err}),
          32'({1'b1, 10'(10'h100 + i), 1'b0}));
    end
    drive(1'b1, OP_LOOP_OPEN, 10'h200, 1'b0);
    chk("overflow_ready", 32'(bus.instr_ready), 32'h1);
    step();
    chk("overflow_no_push", 32'({bus.stk_push, bus.stk_pop, bus.err, bus.instr_ready}), 32'b0010);
    do_reset();
    drive(1'b1, OP_LOOP_OPEN, 10'h040, 1'b0);
    step();
    drive(1'b1, OP_LOOP_CLOSE, 10'h041, 1'b0);
    step();
    chk("pop_before_abort", 32'({bus.stk_pop, bus.instr_ready}), 32'b10);
    drive(1'b0, 8'h00, 10'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_pop_outs", 32'(outs()), 32'h0);
    chk("abort_pop_ready", 32'(bus.instr_ready), 32'h1);
    step();
    chk("abort_no_load", 32'({bus.pc_load, bus.stk_pop}), 32'h0);
    drive(1'b1, OP_LOOP_OPEN, 10'h050, 1'b1);
    step();
    chk("skip_entered", 32'(bus.skip), 32'h1);
    drive(1'b0, 8'h00, 10'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_skip", 32'({bus.skip, bus.instr_ready, bus.err}), 32'b010);
    drive(1'b1, OP_LOOP_CLOSE, 10'h051, 1'b1);
    step();
    chk("skip_abort_depth0", 32'(bus.err), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loop_controller.md
# loop_controller

Loop-control unit of the brainfuck core that drives the loop stack's push/pop/address port. It watches every accepted instruction, pushes the PC of each `[` and pops on each `]`. It redirects fetch back to the matching `[` while the current cell is nonzero. When a `[` is reached with a zero cell, it scans forward past the matching `]`. It sits between fetch/decode and execute, alongside the loop stack.

## Interface
- `ADDR_W`, 10, program-address width; must match the loop stack.
- `DEPTH`, 32, loop-stack capacity and maximum skip nesting.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  fetch presents an instruction.
- `instr`  in  8  ASCII opcode.
- `instr_pc`  in  ADDR_W  address of `instr`.
- `instr_ready`  out  1  controller accepts `instr` this cycle.
- `cell_zero`  in  1  current data cell == 0; sampled only on acceptance.
- `skip`  out  1  high while forward-scanning; execute must ignore the instructions accepted during this time.
- `pc_load`  out  1  one-cycle redirect strobe to fetch.
- `pc_target`  out  ADDR_W  redirect address; valid while `pc_load` is high.
- `stk_push`  out  1  push pulse to the loop stack.
- `stk_pop`  out  1  pop pulse to the loop stack.
- `stk_addr_out`  out  ADDR_W  value to push (stack `address_in`).
- `stk_addr_in`  in  ADDR_W  popped value (stack `address_out`).
- `err`  out  1  sticky fault flag.

## Operation
- An instruction is accepted on a rising edge with `instr_valid & instr_ready`.
- States: RUN, SKIP, POP, WAIT, LOAD, ERR.
- RUN (`instr_ready`=1):
  - `[` with cell nonzero: next cycle `stk_push`=1 and `stk_addr_out`=`instr_pc`; `depth`+1.
  - `[` with cell zero: go to SKIP with `nest`=1; no push.
  - `]`: `depth`-1; next cycle `stk_pop`=1.
    - Cell zero: stay in RUN (pop and discard).
    - Cell nonzero: go to POP.
  - Any other opcode: no action.
- SKIP (`instr_ready`=1, `skip`=1):
  - `[`: `nest`+1.
  - `]`: `nest`-1. When `nest` reaches 0, that `]` is consumed and the controller returns to RUN; `skip` drops in the following cycle.
  - No stack traffic occurs during SKIP.
- POP: `stk_pop`=1, then go to WAIT.
- WAIT: capture `stk_addr_in` into the target register at the end of the cycle, then go to LOAD.
- LOAD: `pc_load`=1 with `pc_target`=captured address, then go to RUN.
  - Fetch restarts at the `[`, which re-evaluates and pushes again.
  - Fetch discards anything in flight.
- `instr_ready`=0 in POP, WAIT, LOAD and ERR.
- ERR conditions (state moves to ERR and stays there until `rst`):
  - `[` push with `depth`==DEPTH.
  - `]` with `depth`==0 (RUN).
  - `[` in SKIP with `nest`==DEPTH.
- In ERR, `err`=1 and `instr_ready`=0; no push or pop is issued for the faulting instruction.
- `stk_push` and `stk_pop` are never high together and are never high for more than one consecutive cycle per instruction.
- `depth` and `nest` are $clog2(DEPTH)+1 bits wide, unsigned, and never wrap.

## Timing
- Reset values:
  - state=RUN, `depth`=0, `nest`=0.
  - `instr_ready`=1, `skip`=0, `err`=0.
  - `pc_load`=0, `pc_target`=0.
  - `stk_push`=0, `stk_pop`=0, `stk_addr_out`=0.
- Reset mid-operation (SKIP, POP, WAIT or LOAD) aborts the operation with no strobes in the following cycle. The external stack must be reset together with this block.
- All outputs are registered, except `instr_ready`, which is decoded from state.
- `[` push: `stk_push` pulses 1 cycle after acceptance. Back-to-back acceptance is allowed.
- `]` jump-back: accept at edge E0, `stk_pop` during cycle E0→E1, WAIT during E1→E2, `pc_load` during E2→E3; `instr_ready` returns high at E3.
- `]` exit (cell zero): zero stall; `stk_pop` pulses 1 cycle after acceptance.
- The loop stack presents the popped value on `stk_addr_in` no later than the end of the cycle following `stk_pop`.

## Structure
- Shared package `bf_pkg` holds:
  - `ADDR_W`.
  - `OP_LOOP_OPEN`=8'h5B, `OP_LOOP_CLOSE`=8'h5D.
  - The other opcode constants.
  - The `loop_state_t` enum: RUN, SKIP, POP, WAIT, LOAD, ERR.
- No sub-module: one FSM plus the depth, nest and target registers. The loop stack stays external.

## Test plan
- `[`@0x010 with cell nonzero, then `+` → `stk_push`=1 with `stk_addr_out`=0x010 the next cycle; `depth`=1; no stall.
- Program `[ [ ] ]` with cell zero at the first `[` → `skip`=1 across all four instructions; no `stk_push` or `stk_pop`; RUN resumes after the fourth.
- `[`@0x020 pushed, then `]`@0x025 with cell nonzero → `stk_pop` at E0+1, stack returns 0x020, `pc_load`=1 with `pc_target`=0x020 at E0+2; `instr_ready` is 0 for 3 cycles.
- `]` with cell zero after one push → single `stk_pop`, `depth`=0, `pc_load` stays 0.
- `]` at `depth`=0 → `err`=1 and `instr_ready`=0 persist; `rst` clears both.
- 32 nested `[` with cell nonzero, then a 33rd `[` → ERR with no 33rd push.
